// File: rtl/reg_file_2r1w_if.sv
// Bus bundle for reg_file_2r1w: one write port, two read ports, clear request/busy.
interface reg_file_2r1w_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              WrEn;
  logic [ADDR_W-1:0] WrAddr;
  logic [WIDTH-1:0]  WrData;
  logic              RdEn0;
  logic [ADDR_W-1:0] RdAddr0;
  logic [WIDTH-1:0]  RdData0;
  logic              RdValid0;
  logic              RdEn1;
  logic [ADDR_W-1:0] RdAddr1;
  logic [WIDTH-1:0]  RdData1;
  logic              RdValid1;
  logic              ClrReq;
  logic              Busy;

  modport master (
    output WrEn, WrAddr, WrData, RdEn0, RdAddr0, RdEn1, RdAddr1, ClrReq,
    input  RdData0, RdValid0, RdData1, RdValid1, Busy
  );

  modport slave (
    input  WrEn, WrAddr, WrData, RdEn0, RdAddr0, RdEn1, RdAddr1, ClrReq,
    output RdData0, RdValid0, RdData1, RdValid1, Busy
  );
endinterface

// File: rtl/reg_file_2r1w.sv
// Register file with one write port, two registered write-first read ports and a
// sequenced clear-all that sweeps one entry per cycle while Busy is high.
//
// state | meaning
// IDLE  | user writes accepted, ClrReq starts a sweep
// CLEAR | entry[ptr] zeroed each cycle, user writes and ClrReq ignored
module reg_file_2r1w #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input logic              CLK,
  input logic              RST,
  reg_file_2r1w_if.slave   bus
);
  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [WIDTH-1:0]  rd_data0_q, rd_data0_d;
  logic [WIDTH-1:0]  rd_data1_q, rd_data1_d;
  logic              rd_valid0_q, rd_valid0_d;
  logic              rd_valid1_q, rd_valid1_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    mem_d   = mem_q;
    case (state_q)
      IDLE: begin
        if (bus.WrEn) mem_d[bus.WrAddr] = bus.WrData;
        if (bus.ClrReq) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        mem_d[ptr_q] = '0;
        ptr_d        = ptr_q + ADDR_W'(1);
        if (ptr_q == ADDR_W'(DEPTH - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reads index the post-write array, which gives write-first bypass for free.
    rd_data0_d  = bus.RdEn0 ? mem_d[bus.RdAddr0] : rd_data0_q;
    rd_data1_d  = bus.RdEn1 ? mem_d[bus.RdAddr1] : rd_data1_q;
    rd_valid0_d = bus.RdEn0;
    rd_valid1_d = bus.RdEn1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_data0_q  <= '0;
      rd_data1_q  <= '0;
      rd_valid0_q <= 1'b0;
      rd_valid1_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      mem_q       <= mem_d;
      rd_data0_q  <= rd_data0_d;
      rd_data1_q  <= rd_data1_d;
      rd_valid0_q <= rd_valid0_d;
      rd_valid1_q <= rd_valid1_d;
    end
  end

  assign bus.RdData0  = rd_data0_q;
  assign bus.RdData1  = rd_data1_q;
  assign bus.RdValid0 = rd_valid0_q;
  assign bus.RdValid1 = rd_valid1_q;
  assign bus.Busy     = (state_q == CLEAR);
endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench for reg_file_2r1w: a 16x8 instance and a 32x32 instance on one clock.
module tb_reg_file_2r1w;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_file_2r1w_if #(.WIDTH(16), .DEPTH(8))  ia ();
  reg_file_2r1w_if #(.WIDTH(32), .DEPTH(32)) ib ();

  reg_file_2r1w #(.WIDTH(16), .DEPTH(8))  dut_a (.CLK(clk), .RST(rst), .bus(ia));
  reg_file_2r1w #(.WIDTH(32), .DEPTH(32)) dut_b (.CLK(clk), .RST(rst), .bus(ib));

  int vectors     = 0;
  int miscompares = 0;
  int n_busy;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    ia.WrEn = 1'b1; ia.WrAddr = a; ia.WrData = d;
    tick();
    ia.WrEn = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a0, input logic [2:0] a1);
    ia.RdEn0 = 1'b1; ia.RdAddr0 = a0;
    ia.RdEn1 = 1'b1; ia.RdAddr1 = a1;
    tick();
    ia.RdEn0 = 1'b0; ia.RdEn1 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ia.WrEn = 0; ia.WrAddr = '0; ia.WrData = '0; ia.RdEn0 = 0; ia.RdAddr0 = '0;
    ia.RdEn1 = 0; ia.RdAddr1 = '0; ia.ClrReq = 0;
    ib.WrEn = 0; ib.WrAddr = '0; ib.WrData = '0; ib.RdEn0 = 0; ib.RdAddr0 = '0;
    ib.RdEn1 = 0; ib.RdAddr1 = '0; ib.ClrReq = 0;
    tick();
    check_val("rst_busy", 32'(ia.Busy), 0);
    check_val("rst_valid0", 32'(ia.RdValid0), 0);
    check_val("rst_data0", 32'(ia.RdData0), 0);
    tick();
    rst = 1'b0;

    // Mid-simulation reset wipes stored data and the read registers immediately.
    wr(3'd4, 16'h1111);
    rd(3'd4, 3'd4);
    check_val("pre_rst_rd0", 32'(ia.RdData0), 32'h1111);
    rst = 1'b1;
    #1;
    check_val("async_rst_rd0", 32'(ia.RdData0), 0);
    check_val("async_rst_v0", 32'(ia.RdValid0), 0);
    #1;
    rst = 1'b0;
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), 3'(7 - a));
      check_val($sformatf("rst_rd0_a%0d", a), 32'(ia.RdData0), 0);
      check_val($sformatf("rst_rd1_a%0d", 7 - a), 32'(ia.RdData1), 0);
      check_val($sformatf("rst_v0_a%0d", a), 32'(ia.RdValid0), 1);
      check_val($sformatf("rst_v1_a%0d", a), 32'(ia.RdValid1), 1);
    end
    tick();
    check_val("rst_v0_drop", 32'(ia.RdValid0), 0);
    check_val("rst_v1_drop", 32'(ia.RdValid1), 0);
    check_val("rst_busy_after", 32'(ia.Busy), 0);

    // Dual-port read, then hold.
    wr(3'd3, 16'hA5A5);
    wr(3'd5, 16'h1234);
    rd(3'd3, 3'd5);
    check_val("dual_rd0", 32'(ia.RdData0), 32'hA5A5);
    check_val("dual_rd1", 32'(ia.RdData1), 32'h1234);
    check_val("dual_v0", 32'(ia.RdValid0), 1);
    check_val("dual_v1", 32'(ia.RdValid1), 1);
    tick();
    check_val("hold_rd0", 32'(ia.RdData0), 32'hA5A5);
    check_val("hold_rd1", 32'(ia.RdData1), 32'h1234);
    check_val("hold_v0", 32'(ia.RdValid0), 0);
    check_val("hold_v1", 32'(ia.RdValid1), 0);

    // Write-first bypass on both ports.
    ia.WrEn = 1; ia.WrAddr = 3'd2; ia.WrData = 16'hBEEF;
    ia.RdEn0 = 1; ia.RdAddr0 = 3'd2; ia.RdEn1 = 1; ia.RdAddr1 = 3'd2;
    tick();
    ia.WrEn = 0; ia.RdEn0 = 0; ia.RdEn1 = 0;
    check_val("byp_rd0", 32'(ia.RdData0), 32'hBEEF);
    check_val("byp_rd1", 32'(ia.RdData1), 32'hBEEF);

    // Clear sweep over a full file of 0xFFFF.
    for (int a = 0; a < 8; a++) wr(3'(a), 16'hFFFF);
    ia.ClrReq = 1;
    tick();
    ia.ClrReq = 0;
    n_busy = 0;
    for (int i = 0; i < 40 && ia.Busy; i++) begin
      n_busy++;
      case (i)
        0: begin ia.WrEn = 1; ia.WrAddr = 3'd7; ia.WrData = 16'h5555; end
        1: begin ia.WrEn = 1; ia.WrAddr = 3'd0; ia.WrData = 16'h5555; end
        2: begin ia.RdEn0 = 1; ia.RdAddr0 = 3'd6; end
        default: ;
      endcase
      tick();
      ia.WrEn = 0; ia.RdEn0 = 0;
      if (i == 2) check_val("clr_rd6_mid", 32'(ia.RdData0), 32'hFFFF);
    end
    check_val("clr_busy_cycles", 32'(n_busy), 8);
    rd(3'd7, 3'd0);
    check_val("clr_drop_a7", 32'(ia.RdData0), 0);
    check_val("clr_drop_a0", 32'(ia.RdData1), 0);
    rd(3'd6, 3'd3);
    check_val("clr_a6", 32'(ia.RdData0), 0);
    check_val("clr_a3", 32'(ia.RdData1), 0);

    // ClrReq with a same-edge write; ClrReq repeated while busy is ignored.
    ia.ClrReq = 1; ia.WrEn = 1; ia.WrAddr = 3'd1; ia.WrData = 16'h7777;
    tick();
    ia.ClrReq = 0; ia.WrEn = 0;
    n_busy = 0;
    for (int i = 0; i < 40 && ia.Busy; i++) begin
      n_busy++;
      ia.ClrReq = (i == 3 || i == 7);
      tick();
      ia.ClrReq = 0;
    end
    check_val("clr2_busy_cycles", 32'(n_busy), 8);
    rd(3'd1, 3'd1);
    check_val("clr2_a1", 32'(ia.RdData0), 0);

    // Back-to-back request right after Busy falls.
    ia.ClrReq = 1;
    tick();
    ia.ClrReq = 0;
    check_val("clr3_accept", 32'(ia.Busy), 1);
    n_busy = 0;
    for (int i = 0; i < 40 && ia.Busy; i++) begin
      n_busy++;
      tick();
    end
    check_val("clr3_busy_cycles", 32'(n_busy), 8);

    // Reset during the 4th busy cycle.
    for (int a = 0; a < 8; a++) wr(3'(a), 16'hAAAA);
    ia.ClrReq = 1;
    tick();
    ia.ClrReq = 0;
    tick();
    tick();
    tick();
    check_val("rst_clr_busy_pre", 32'(ia.Busy), 1);
    rst = 1'b1;
    #1;
    check_val("rst_clr_busy", 32'(ia.Busy), 0);
    #1;
    rst = 1'b0;
    for (int a = 0; a < 8; a += 2) begin
      rd(3'(a), 3'(a + 1));
      check_val($sformatf("rst_clr_a%0d", a), 32'(ia.RdData0), 0);
      check_val($sformatf("rst_clr_a%0d", a + 1), 32'(ia.RdData1), 0);
      check_val("rst_clr_no_resume", 32'(ia.Busy), 0);
    end

    // 32x32 instance.
    ib.WrEn = 1; ib.WrAddr = 5'd31; ib.WrData = 32'hDEADBEEF;
    tick();
    ib.WrAddr = 5'd0; ib.WrData = 32'h0123_4567;
    ib.RdEn1 = 1; ib.RdAddr1 = 5'd31;
    ib.RdEn0 = 1; ib.RdAddr0 = 5'd0;
    tick();
    ib.WrEn = 0; ib.RdEn0 = 0; ib.RdEn1 = 0;
    check_val("w32_rd1_a31", ib.RdData1, 32'hDEADBEEF);
    check_val("w32_rd0_byp", ib.RdData0, 32'h0123_4567);
    ib.ClrReq = 1;
    tick();
    ib.ClrReq = 0;
    n_busy = 0;
    for (int i = 0; i < 100 && ib.Busy; i++) begin
      n_busy++;
      tick();
    end
    check_val("w32_busy_cycles", 32'(n_busy), 32);
    ib.RdEn0 = 1; ib.RdAddr0 = 5'd31; ib.RdEn1 = 1; ib.RdAddr1 = 5'd0;
    tick();
    ib.RdEn0 = 0; ib.RdEn1 = 0;
    check_val("w32_clr_a31", ib.RdData0, 0);
    check_val("w32_clr_a0", ib.RdData1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
